// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, idle pin values and
// the one-hot state encoding of the pin arbiter.
package sdram_pkg;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP        = 4'b1000;
   localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
   localparam logic [3:0] CMD_READ       = 4'b0101;
   localparam logic [3:0] CMD_WRITE      = 4'b0100;
   localparam logic [3:0] CMD_BURST_TERM = 4'b0110;
   localparam logic [3:0] CMD_PRE_CHARG  = 4'b0010;
   localparam logic [3:0] CMD_AREF       = 4'b0001;

   localparam logic [1:0]  BA_IDLE   = 2'b11;
   localparam logic [12:0] ADDR_IDLE = 13'h1fff;

   typedef enum logic [4:0] {
      ST_INIT  = 5'b00001,
      ST_ARBIT = 5'b00010,
      ST_AREF  = 5'b00100,
      ST_WRITE = 5'b01000,
      ST_READ  = 5'b10000
   } arb_state_e;

endpackage

// File: rtl/sdram_arbit.sv
// Hands the shared SDRAM pins to init, refresh, write or read, one at a time.
// Refresh has priority; write and read alternate when both are pending.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter logic [3:0]  CMD_NOP   = 4'b1000,
   parameter logic [1:0]  BA_IDLE   = 2'b11,
   parameter logic [12:0] ADDR_IDLE = 13'h1fff
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_end,
   input  logic [3:0]  init_cmd,
   input  logic [1:0]  init_ba,
   input  logic [12:0] init_addr,
   input  logic        aref_req,
   input  logic        aref_end,
   input  logic [3:0]  aref_cmd,
   input  logic [1:0]  aref_ba,
   input  logic [12:0] aref_addr,
   input  logic        wr_req,
   input  logic        rd_req,
   input  logic        wr_end,
   input  logic        rd_end,
   input  logic [3:0]  wr_cmd,
   input  logic [1:0]  wr_ba,
   input  logic [12:0] wr_addr,
   input  logic [3:0]  rd_cmd,
   input  logic [1:0]  rd_ba,
   input  logic [12:0] rd_addr,
   input  logic        wr_sdram_en,
   input  logic [15:0] wr_sdram_data,
   output logic        aref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic        sdram_cke,
   output logic        sdram_cs_n,
   output logic        sdram_ras_n,
   output logic        sdram_cas_n,
   output logic        sdram_we_n,
   output logic [1:0]  sdram_ba,
   output logic [12:0] sdram_addr,
   inout  wire  [15:0] sdram_dq
);

   arb_state_e state_q, state_d;
   logic       last_grant_q, last_grant_d;   // 1 = write granted last, 0 = read
   logic [3:0] cmd;

   // NOTE: state flops use non-blocking assignment; the comb process below uses blocking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INIT;
         last_grant_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // NOTE: defaults first so every path assigns every output -- no latches.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_INIT:  if (init_end) state_d = ST_ARBIT;
         ST_ARBIT: begin
            if (aref_req) begin
               state_d = ST_AREF;
            end else if (wr_req && rd_req) begin
               state_d      = last_grant_q ? ST_READ : ST_WRITE;
               last_grant_d = ~last_grant_q;
            end else if (wr_req) begin
               state_d      = ST_WRITE;
               last_grant_d = 1'b1;
            end else if (rd_req) begin
               state_d      = ST_READ;
               last_grant_d = 1'b0;
            end
         end
         ST_AREF:  if (aref_end) state_d = ST_ARBIT;
         ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
         ST_READ:  if (rd_end)   state_d = ST_ARBIT;
         default:  state_d = init_end ? ST_ARBIT : ST_INIT;
      endcase
   end

   assign aref_en = (state_q == ST_AREF);
   assign wr_en   = (state_q == ST_WRITE);
   assign rd_en   = (state_q == ST_READ);

   // Engines register their own pin values, so the mux adds no latency.
   always_comb begin
      cmd        = CMD_NOP;
      sdram_ba   = BA_IDLE;
      sdram_addr = ADDR_IDLE;
      case (state_q)
         ST_INIT: begin
            cmd = init_cmd;  sdram_ba = init_ba;  sdram_addr = init_addr;
         end
         ST_AREF: begin
            cmd = aref_cmd;  sdram_ba = aref_ba;  sdram_addr = aref_addr;
         end
         ST_WRITE: begin
            cmd = wr_cmd;    sdram_ba = wr_ba;    sdram_addr = wr_addr;
         end
         ST_READ: begin
            cmd = rd_cmd;    sdram_ba = rd_ba;    sdram_addr = rd_addr;
         end
         default: ;
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
   assign sdram_cke = 1'b1;

   assign sdram_dq = (state_q == ST_WRITE && wr_sdram_en) ? wr_sdram_data : 16'hzzzz;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: reset/init hand-off, refresh priority,
// write/read alternation, pin mux, DQ tristate and asynchronous reset.
module tb_sdram_arbit;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_end;
   logic [3:0]  init_cmd;
   logic [1:0]  init_ba;
   logic [12:0] init_addr;
   logic        aref_req, aref_end;
   logic [3:0]  aref_cmd;
   logic [1:0]  aref_ba;
   logic [12:0] aref_addr;
   logic        wr_req, rd_req, wr_end, rd_end;
   logic [3:0]  wr_cmd, rd_cmd;
   logic [1:0]  wr_ba, rd_ba;
   logic [12:0] wr_addr, rd_addr;
   logic        wr_sdram_en;
   logic [15:0] wr_sdram_data;
   logic        aref_en, wr_en, rd_en, sdram_cke;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   tri1  [15:0] sdram_dq;   // undriven bus reads back as 16'hffff

   int n_tests = 0;
   int n_fail  = 0;

   sdram_arbit dut (
      .clk(clk), .rst(rst), .init_end(init_end),
      .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
      .aref_req(aref_req), .aref_end(aref_end),
      .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
      .wr_req(wr_req), .rd_req(rd_req), .wr_end(wr_end), .rd_end(rd_end),
      .wr_cmd(wr_cmd), .wr_ba(wr_ba), .wr_addr(wr_addr),
      .rd_cmd(rd_cmd), .rd_ba(rd_ba), .rd_addr(rd_addr),
      .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the active edge; outputs are checked 1 ns after that.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_grants(input string tag, input logic [2:0] exp);
      check(tag, {29'd0, aref_en, wr_en, rd_en}, {29'd0, exp});
   endtask

   task automatic check_pins(input string tag, input logic [3:0] c, input logic [1:0] b,
                             input logic [12:0] a);
      check(tag, {13'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr},
                 {13'd0, c, b, a});
   endtask

   initial begin
      rst = 1'b1;        init_end = 1'b0;
      init_cmd = 4'b0010; init_ba = 2'b01; init_addr = 13'h0400;
      aref_req = 0; aref_end = 0; aref_cmd = 4'b0001; aref_ba = 2'b00; aref_addr = 13'h0123;
      wr_req = 0; rd_req = 0; wr_end = 0; rd_end = 0;
      wr_cmd = 4'b0100; wr_ba = 2'b10; wr_addr = 13'h0222;
      rd_cmd = 4'b0101; rd_ba = 2'b01; rd_addr = 13'h0040;
      wr_sdram_en = 1'b1; wr_sdram_data = 16'ha5a5;

      // Reset: INIT, no grants, cke high, pins follow the init engine, DQ released
      #3;
      check_grants("rst_grants", 3'b000);
      check("rst_cke", {31'd0, sdram_cke}, 32'd1);
      check_pins("rst_pins_init", 4'b0010, 2'b01, 13'h0400);
      check("rst_dq_z", {16'd0, sdram_dq}, 32'h0000ffff);
      #10 rst = 1'b0;
      tick();
      check_pins("init_hold", 4'b0010, 2'b01, 13'h0400);

      init_end = 1'b1;
      tick();
      check_pins("arbit_idle", 4'b1000, 2'b11, 13'h1fff);
      check_grants("arbit_grants", 3'b000);

      // All three request together: refresh first
      aref_req = 1; wr_req = 1; rd_req = 1;
      tick();
      check_grants("aref_first", 3'b100);
      check_pins("aref_pins", 4'b0001, 2'b00, 13'h0123);
      aref_req = 0; aref_end = 1;
      tick();
      aref_end = 0; #1;
      check_grants("aref_end_arbit", 3'b000);
      check_pins("aref_end_idle", 4'b1000, 2'b11, 13'h1fff);
      tick();

      // W, R, W, R with 3-cycle jobs, one ARBIT cycle between grants
      for (int g = 0; g < 4; g++) begin
         if (g % 2 == 0) begin
            wr_sdram_en = 1'b1; #1;
            check_grants($sformatf("alt%0d_w", g), 3'b010);
            check_pins($sformatf("alt%0d_wpins", g), 4'b0100, 2'b10, 13'h0222);
            check($sformatf("alt%0d_dq_drv", g), {16'd0, sdram_dq}, 32'h0000a5a5);
            tick();
            wr_sdram_en = 1'b0; #1;
            check($sformatf("alt%0d_dq_off", g), {16'd0, sdram_dq}, 32'h0000ffff);
            tick();
            wr_end = 1;
            tick();
            wr_end = 0; wr_sdram_en = 1'b1; #1;
         end else begin
            check_grants($sformatf("alt%0d_r", g), 3'b001);
            check_pins($sformatf("alt%0d_rpins", g), 4'b0101, 2'b01, 13'h0040);
            check($sformatf("alt%0d_dq_rd", g), {16'd0, sdram_dq}, 32'h0000ffff);
            tick();
            check_grants($sformatf("alt%0d_r_hold", g), 3'b001);
            tick();
            rd_end = 1;
            tick();
            rd_end = 0; #1;
         end
         check_grants($sformatf("alt%0d_gap", g), 3'b000);
         check_pins($sformatf("alt%0d_gap_pins", g), 4'b1000, 2'b11, 13'h1fff);
         check($sformatf("alt%0d_gap_dq", g), {16'd0, sdram_dq}, 32'h0000ffff);
         tick();
      end

      // Back to write after R; reset it asynchronously mid-grant
      check_grants("pre_rst_w", 3'b010);
      init_cmd = 4'b1000; init_ba = 2'b11; init_addr = 13'h1fff; init_end = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_grants("async_rst_grants", 3'b000);
      check_pins("async_rst_pins", 4'b1000, 2'b11, 13'h1fff);
      check("async_rst_dq", {16'd0, sdram_dq}, 32'h0000ffff);
      #4 rst = 1'b0;
      tick();
      init_cmd = 4'b0111; #1;
      check_pins("post_rst_init", 4'b0111, 2'b11, 13'h1fff);

      // last_grant cleared by reset: write wins the tie again
      init_end = 1'b1;
      tick();
      check_grants("post_rst_arbit", 3'b000);
      tick();
      check_grants("post_rst_w_first", 3'b010);

      // Refresh mid-burst waits for wr_end, then beats the pending read
      aref_req = 1;
      tick();
      check_grants("no_preempt", 3'b010);
      wr_end = 1;
      tick();
      wr_end = 0; #1;
      check_grants("preempt_gap", 3'b000);
      tick();
      check_grants("aref_after_w", 3'b100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
